up_mem_arbiter: RTL and testbench
=================================

// Module: up_mem_arbiter
// PURPOSE
//  Shares the processor's single external memory bus between two requesters: the CPU controller on port 0
//  and the DMA/program loader on port 1. Grants are round-robin, and only one transaction is active at a time.
//  Each transaction is an ALE address phase followed by a data phase that ends on mem_rdy or on a timeout.
//  The block sits between the controller/datapath and the memory pins.
// PARAMETERS
//  AW        8   address width
//  DW        8   data width
//  WAIT_MAX  15  maximum DATA-phase cycles spent waiting for mem_rdy before abort (legal 1..255)
// PORTS
//  clk        in   1   clock, rising edge
//  Rst        in   1   synchronous, active-high reset
//  req0/req1  in   1   transaction request, port 0/1
//  we0/we1    in   1   1=write, 0=read, port 0/1
//  addr0/1    in   AW  address, port 0/1
//  wdata0/1   in   DW  write data, port 0/1
//  gnt0/gnt1  out  1   port owns the bus; high from ADDR through DONE
//  done       out  1   1-cycle pulse at transaction end, for the granted port
//  err        out  1   1-cycle pulse coincident with done when the transaction timed out
//  rdata      out  DW  captured read data; valid from the done cycle until the next successful read
//  mem_ale    out  1   address latch enable
//  mem_re     out  1   memory read strobe
//  mem_we     out  1   memory write strobe
//  mem_addr   out  AW  memory address
//  mem_wdata  out  DW  memory write data
//  mem_rdata  in   DW  memory read data
//  mem_rdy    in   1   memory data-phase complete
// BEHAVIOUR
//  Regs: state{IDLE,ADDR,DATA,DONE} (2b); owner (1b); last (1b); we_q/addr_q/wdata_q; cnt (8b); err_q; rdata.
//  All outputs decode from registered state/regs; no input->output combinational path.
//  Reset: state=IDLE, last=1 so port 0 wins the first tie; owner, cnt, err_q, rdata, addr_q and wdata_q = 0.
//    After reset, every output reads 0.
//  IDLE: no req -> stay in IDLE.
//    Exactly one req -> that port wins.
//    Both req -> the port != last wins.
//    On a win: latch the winner's we/addr/wdata and set owner; go to ADDR; clear cnt and err_q.
//  ADDR (exactly 1 cycle): mem_ale=1, mem_addr=addr_q, gnt[owner]=1 -> DATA.
//  DATA: mem_re=~we_q, mem_we=we_q, mem_addr=addr_q, mem_wdata=wdata_q, gnt[owner]=1.
//    mem_rdy=1 -> a read captures mem_rdata into rdata -> DONE.
//    mem_rdy=0 and cnt==WAIT_MAX-1 -> err_q=1 -> DONE. Otherwise cnt++ and stay in DATA.
//    DATA lasts at most WAIT_MAX cycles; mem_rdy in any of them completes the transaction normally.
//  DONE (exactly 1 cycle): done=1, err=err_q, gnt[owner]=1, last<=owner -> IDLE.
//  Outside DATA, mem_re, mem_we, mem_wdata and mem_addr are 0, except mem_addr=addr_q in ADDR.
//  Latency: req seen in IDLE cycle N -> ale at N+1, DATA from N+2, done at N+3 at the earliest.
//    Back-to-back transactions take at least 4 cycles each, since IDLE is always 1 cycle.
//  Requests are sampled only in IDLE. Dropping req mid-transaction is ignored and the transaction completes.
//    A req still high in the IDLE after DONE is a new request, arbitrated round-robin.
//  Writes and timed-out reads leave rdata unchanged.
//  mem_rdy outside DATA is ignored.
//  Invariants: gnt0&gnt1 never both high; mem_re&mem_we never both high; mem_ale never high in DATA.
//  Rst mid-transaction: the next cycle is IDLE with all outputs 0. No done/err pulse. last=1.
// TESTING
//  1. Port-0 read of 0x3C, mem_rdata=0xA5, mem_rdy high on the first DATA cycle
//       -> ale N+1, re N+2, done N+3, rdata=0xA5, gnt0 high N+1..N+3, gnt1 low throughout.
//  2. req0 and req1 both held high from reset
//       -> grants alternate 0,1,0,1 with transactions 4 cycles apart; no overlapping gnt.
//  3. Port-1 write addr=0x80, wdata=0x5A, mem_rdy delayed 3 cycles
//       -> mem_we high 4 DATA cycles, mem_wdata=0x5A, done without err, rdata unchanged.
//  4. WAIT_MAX=15 read with mem_rdy held 0
//       -> exactly 15 DATA cycles, then done=err=1, rdata unchanged, next IDLE grants normally.
//  5. Rst asserted for 1 cycle during DATA
//       -> next cycle all outputs 0, no done; the following simultaneous req0/req1 grants port 0.
//  6. req0 dropped during ADDR
//       -> transaction still completes with done; no new grant while req0 stays low.

Source files
------------

// File: rtl/up_mem_arbiter.sv
// -----------------------------------------------------------------------------
// up_mem_arbiter
//
// Shares the single external memory bus between the CPU controller (port 0)
// and the DMA/program loader (port 1). Grants are round-robin and only one
// transaction is active at a time. Each transaction is a one-cycle ALE
// address phase and then a data phase. The data phase ends when mem_rdy is
// seen, or it aborts after WAIT_MAX cycles without mem_rdy.
//
// Parameters
//   AW        address width
//   DW        data width
//   WAIT_MAX  maximum data-phase cycles spent waiting for mem_rdy (1..255)
//
// Ports
//   clk                 clock, rising edge
//   Rst                 synchronous, active-high reset
//   req0/req1           transaction request, port 0/1
//   we0/we1             1 = write, 0 = read, port 0/1
//   addr0/addr1         address, port 0/1
//   wdata0/wdata1       write data, port 0/1
//   gnt0/gnt1           port owns the bus (ADDR through DONE)
//   done                1-cycle pulse at transaction end
//   err                 1-cycle pulse with done when the data phase timed out
//   rdata               data captured by the last successful read
//   mem_ale             address latch enable
//   mem_re / mem_we     memory read / write strobes
//   mem_addr            memory address
//   mem_wdata           memory write data
//   mem_rdata           memory read data
//   mem_rdy             memory data-phase complete
//
// Every output is decoded from registered state only. No input reaches an
// output through a combinational path.
// -----------------------------------------------------------------------------
module up_mem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int WAIT_MAX = 15
) (
  input  logic          clk,
  input  logic          Rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] rdata,
  output logic          mem_ale,
  output logic          mem_re,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_rdy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Last data-phase cycle before the transaction is aborted.
  localparam logic [7:0] CNT_LAST = 8'(WAIT_MAX - 1);

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          winner;

  // Winner of the IDLE arbitration. A lone request wins outright. On a tie,
  // the port that did not own the previous transaction wins.
  always_comb begin
    winner = req1;
    if (req0 && req1) begin
      winner = ~last_q;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first. If a
    // case branch then leaves it unassigned, it holds its value and no latch
    // is inferred.
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          owner_d = winner;
          we_d    = winner ? we1    : we0;
          addr_d  = winner ? addr1  : addr0;
          wdata_d = winner ? wdata1 : wdata0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = S_ADDR;
        end
      end

      S_ADDR: begin
        state_d = S_DATA;
      end

      S_DATA: begin
        if (mem_rdy) begin
          if (!we_q) begin
            rdata_d = mem_rdata;
          end
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_DONE: begin
        last_d  = owner_q;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments. Every register
    // then updates from values taken before the edge, so the result does not
    // depend on the order of the processes.
    if (Rst) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;  // port 0 wins the first tie after reset
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Output decode, driven from registered state only
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    mem_ale   = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    if (state_q != S_IDLE) begin
      gnt0 = ~owner_q;
      gnt1 = owner_q;
    end

    unique case (state_q)
      S_ADDR: begin
        mem_ale  = 1'b1;
        mem_addr = addr_q;
      end
      S_DATA: begin
        mem_re    = ~we_q;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
      end
      S_DONE: begin
        done = 1'b1;
        err  = err_q;
      end
      default: ;
    endcase
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_up_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_up_mem_arbiter
//
// Directed testbench for up_mem_arbiter. Inputs are driven and outputs are
// sampled on the falling clock edge, which is half a cycle away from the
// rising edge that the DUT uses. The control outputs are packed as
//   ctl = {gnt0, gnt1, done, err, mem_ale, mem_re, mem_we}
// and the bench compares ctl against hand-computed values for each cycle.
// -----------------------------------------------------------------------------
module tb_up_mem_arbiter;

  localparam int AW       = 8;
  localparam int DW       = 8;
  localparam int WAIT_MAX = 15;

  logic          clk = 1'b0;
  logic          Rst;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, done, err;
  logic [DW-1:0] rdata;
  logic          mem_ale, mem_re, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_rdy;

  logic [6:0]    ctl;
  assign ctl = {gnt0, gnt1, done, err, mem_ale, mem_re, mem_we};

  int n_checks = 0;
  int n_fails  = 0;

  up_mem_arbiter #(.AW(AW), .DW(DW), .WAIT_MAX(WAIT_MAX)) dut (
    .clk       (clk),
    .Rst       (Rst),
    .req0      (req0),
    .req1      (req1),
    .we0       (we0),
    .we1       (we1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .mem_ale   (mem_ale),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_rdy   (mem_rdy)
  );

  always #5 clk = ~clk;

  // Bus invariants, checked every cycle while out of reset
  always @(negedge clk) begin
    if (Rst === 1'b0) begin
      n_checks++;
      if ((gnt0 & gnt1) !== 1'b0 || (mem_re & mem_we) !== 1'b0 ||
          (mem_ale & (mem_re | mem_we)) !== 1'b0) begin
        n_fails++;
        $display("FAIL invariant: got ctl=%b, want no gnt/strobe overlap", ctl);
      end
    end
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic test_reset;
    Rst = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    mem_rdata = '0; mem_rdy = 0;
    tick; tick; tick;
    n_checks++;
    if (ctl !== 7'b0 || mem_addr !== 8'h00 || mem_wdata !== 8'h00 || rdata !== 8'h00) begin
      n_fails++;
      $display("FAIL reset_outputs: got ctl=%b addr=%h wdata=%h rdata=%h, want all 0",
               ctl, mem_addr, mem_wdata, rdata);
    end
    Rst = 1'b0;
  endtask

  // Port-0 read of 0x3C, mem_rdy already high on the first DATA cycle
  task automatic test_read_port0;
    req0 = 1; we0 = 0; addr0 = 8'h3C; mem_rdata = 8'hA5; mem_rdy = 1;
    tick;  // ADDR (N+1)
    req0 = 0;
    n_checks++;
    if (ctl !== 7'b1000100 || mem_addr !== 8'h3C) begin
      n_fails++;
      $display("FAIL t1_addr: got ctl=%b addr=%h, want 1000100 3c", ctl, mem_addr);
    end
    tick;  // DATA (N+2)
    n_checks++;
    if (ctl !== 7'b1000010 || mem_addr !== 8'h3C || mem_wdata !== 8'h00) begin
      n_fails++;
      $display("FAIL t1_data: got ctl=%b addr=%h wdata=%h, want 1000010 3c 00",
               ctl, mem_addr, mem_wdata);
    end
    tick;  // DONE (N+3)
    mem_rdy = 0;
    n_checks++;
    if (ctl !== 7'b1010000 || rdata !== 8'hA5 || mem_addr !== 8'h00) begin
      n_fails++;
      $display("FAIL t1_done: got ctl=%b rdata=%h addr=%h, want 1010000 a5 00",
               ctl, rdata, mem_addr);
    end
    tick;  // IDLE
    n_checks++;
    if (ctl !== 7'b0 || rdata !== 8'hA5) begin
      n_fails++;
      $display("FAIL t1_idle: got ctl=%b rdata=%h, want 0000000 a5", ctl, rdata);
    end
  endtask

  // Both requests held high from reset: grants alternate 0,1,0,1
  task automatic test_round_robin;
    logic [6:0] g;
    logic [7:0] a;
    Rst = 1;
    tick;
    Rst = 0;
    req0 = 1; req1 = 1; we0 = 0; we1 = 0;
    addr0 = 8'h10; addr1 = 8'h20; mem_rdata = 8'h77; mem_rdy = 1;
    n_checks++;
    if (ctl !== 7'b0 || rdata !== 8'h00) begin
      n_fails++;
      $display("FAIL t2_reset: got ctl=%b rdata=%h, want 0000000 00", ctl, rdata);
    end
    for (int t = 0; t < 4; t++) begin
      g = (t % 2 == 1) ? 7'b0100000 : 7'b1000000;
      a = (t % 2 == 1) ? 8'h20 : 8'h10;
      tick;
      n_checks++;
      if (ctl !== (g | 7'b0000100) || mem_addr !== a) begin
        n_fails++;
        $display("FAIL t2_addr[%0d]: got ctl=%b addr=%h, want %b %h",
                 t, ctl, mem_addr, g | 7'b0000100, a);
      end
      tick;
      n_checks++;
      if (ctl !== (g | 7'b0000010)) begin
        n_fails++;
        $display("FAIL t2_data[%0d]: got ctl=%b, want %b", t, ctl, g | 7'b0000010);
      end
      tick;
      n_checks++;
      if (ctl !== (g | 7'b0010000)) begin
        n_fails++;
        $display("FAIL t2_done[%0d]: got ctl=%b, want %b", t, ctl, g | 7'b0010000);
      end
      tick;
      if (t == 3) begin
        req0 = 0; req1 = 0;
      end
      n_checks++;
      if (ctl !== 7'b0) begin
        n_fails++;
        $display("FAIL t2_idle[%0d]: got ctl=%b, want 0000000", t, ctl);
      end
    end
    tick;
    n_checks++;
    if (ctl !== 7'b0 || rdata !== 8'h77) begin
      n_fails++;
      $display("FAIL t2_end: got ctl=%b rdata=%h, want 0000000 77", ctl, rdata);
    end
  endtask

  // Port-1 write 0x5A to 0x80, mem_rdy delayed 3 cycles
  task automatic test_write_wait;
    req1 = 1; we1 = 1; addr1 = 8'h80; wdata1 = 8'h5A; mem_rdy = 0; mem_rdata = 8'hEE;
    tick;
    req1 = 0;
    n_checks++;
    if (ctl !== 7'b0100100 || mem_addr !== 8'h80 || mem_wdata !== 8'h00) begin
      n_fails++;
      $display("FAIL t3_addr: got ctl=%b addr=%h wdata=%h, want 0100100 80 00",
               ctl, mem_addr, mem_wdata);
    end
    for (int k = 0; k < 4; k++) begin
      tick;
      if (k == 3) mem_rdy = 1;
      n_checks++;
      if (ctl !== 7'b0100001 || mem_addr !== 8'h80 || mem_wdata !== 8'h5A) begin
        n_fails++;
        $display("FAIL t3_data[%0d]: got ctl=%b addr=%h wdata=%h, want 0100001 80 5a",
                 k, ctl, mem_addr, mem_wdata);
      end
    end
    tick;
    mem_rdy = 0;
    n_checks++;
    if (ctl !== 7'b0110000 || rdata !== 8'h77 || mem_wdata !== 8'h00) begin
      n_fails++;
      $display("FAIL t3_done: got ctl=%b rdata=%h wdata=%h, want 0110000 77 00",
               ctl, rdata, mem_wdata);
    end
    tick;
    n_checks++;
    if (ctl !== 7'b0) begin
      n_fails++;
      $display("FAIL t3_idle: got ctl=%b, want 0000000", ctl);
    end
  endtask

  // Read with mem_rdy held low: 15 DATA cycles, then done+err, then a normal grant
  task automatic test_timeout;
    req0 = 1; we0 = 0; addr0 = 8'h44; mem_rdy = 0; mem_rdata = 8'h99;
    tick;
    req0 = 0;
    n_checks++;
    if (ctl !== 7'b1000100 || mem_addr !== 8'h44) begin
      n_fails++;
      $display("FAIL t4_addr: got ctl=%b addr=%h, want 1000100 44", ctl, mem_addr);
    end
    for (int k = 0; k < WAIT_MAX; k++) begin
      tick;
      n_checks++;
      if (ctl !== 7'b1000010) begin
        n_fails++;
        $display("FAIL t4_data[%0d]: got ctl=%b, want 1000010", k, ctl);
      end
    end
    tick;
    // Both ports request for the next IDLE. Port 0 owned the timed-out
    // transaction, so port 1 should win.
    req0 = 1; req1 = 1; we1 = 0; addr1 = 8'h2B; mem_rdy = 1;
    n_checks++;
    if (ctl !== 7'b1011000 || rdata !== 8'h77) begin
      n_fails++;
      $display("FAIL t4_done: got ctl=%b rdata=%h, want 1011000 77", ctl, rdata);
    end
    tick;
    n_checks++;
    if (ctl !== 7'b0) begin
      n_fails++;
      $display("FAIL t4_idle: got ctl=%b, want 0000000", ctl);
    end
    tick;
    req0 = 0; req1 = 0;
    n_checks++;
    if (ctl !== 7'b0100100 || mem_addr !== 8'h2B) begin
      n_fails++;
      $display("FAIL t4_regrant: got ctl=%b addr=%h, want 0100100 2b", ctl, mem_addr);
    end
    tick;
    tick;
    mem_rdy = 0;
    n_checks++;
    if (ctl !== 7'b0110000 || rdata !== 8'h99) begin
      n_fails++;
      $display("FAIL t4_redone: got ctl=%b rdata=%h, want 0110000 99", ctl, rdata);
    end
    tick;
  endtask

  // req0 dropped during ADDR: the write still completes, no new grant follows
  task automatic test_drop_req;
    req0 = 1; we0 = 1; addr0 = 8'h55; wdata0 = 8'hC3; mem_rdy = 1;
    tick;
    req0 = 0;
    n_checks++;
    if (ctl !== 7'b1000100 || mem_addr !== 8'h55) begin
      n_fails++;
      $display("FAIL t6_addr: got ctl=%b addr=%h, want 1000100 55", ctl, mem_addr);
    end
    tick;
    n_checks++;
    if (ctl !== 7'b1000001 || mem_wdata !== 8'hC3) begin
      n_fails++;
      $display("FAIL t6_data: got ctl=%b wdata=%h, want 1000001 c3", ctl, mem_wdata);
    end
    tick;
    mem_rdy = 0;
    n_checks++;
    if (ctl !== 7'b1010000 || rdata !== 8'h99) begin
      n_fails++;
      $display("FAIL t6_done: got ctl=%b rdata=%h, want 1010000 99", ctl, rdata);
    end
    for (int k = 0; k < 3; k++) begin
      tick;
      n_checks++;
      if (ctl !== 7'b0) begin
        n_fails++;
        $display("FAIL t6_idle[%0d]: got ctl=%b, want 0000000", k, ctl);
      end
    end
  endtask

  // Rst during DATA: outputs clear, no done, and port 0 wins the next tie.
  // Before this test, last points at port 0, so only the reset of last
  // makes port 0 the winner here.
  task automatic test_reset_mid;
    req1 = 1; we1 = 0; addr1 = 8'h21; mem_rdy = 0;
    tick;
    req1 = 0;
    n_checks++;
    if (ctl !== 7'b0100100) begin
      n_fails++;
      $display("FAIL t5_addr: got ctl=%b, want 0100100", ctl);
    end
    tick;
    Rst = 1;
    n_checks++;
    if (ctl !== 7'b0100010) begin
      n_fails++;
      $display("FAIL t5_data: got ctl=%b, want 0100010", ctl);
    end
    tick;
    Rst = 0;
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 8'h0F; mem_rdy = 1; mem_rdata = 8'h3E;
    n_checks++;
    if (ctl !== 7'b0 || mem_addr !== 8'h00 || rdata !== 8'h00) begin
      n_fails++;
      $display("FAIL t5_after_rst: got ctl=%b addr=%h rdata=%h, want 0000000 00 00",
               ctl, mem_addr, rdata);
    end
    tick;
    req0 = 0; req1 = 0;
    n_checks++;
    if (ctl !== 7'b1000100 || mem_addr !== 8'h0F) begin
      n_fails++;
      $display("FAIL t5_regrant: got ctl=%b addr=%h, want 1000100 0f", ctl, mem_addr);
    end
    tick;
    tick;
    mem_rdy = 0;
    n_checks++;
    if (ctl !== 7'b1010000 || rdata !== 8'h3E) begin
      n_fails++;
      $display("FAIL t5_done: got ctl=%b rdata=%h, want 1010000 3e", ctl, rdata);
    end
    tick;
  endtask

  initial begin
    test_reset();
    test_read_port0();
    test_round_robin();
    test_write_wait();
    test_timeout();
    test_drop_req();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
